// File: rtl/mac_buf_ctrl_pkg.sv
// Shared defaults for the MAC operand buffer and its pointer controller.
// All parameters of the buffer blocks take their defaults from here.
package mac_buf_ctrl_pkg;

    localparam int BUF_WIDTH_DEF  = 2;
    localparam int BUF_SIZE_DEF   = 4;
    localparam int DATA_WIDTH_DEF = 16;

    // Last valid slot index; both pointers wrap from here back to slot 0.
    function automatic int ptr_wrap(input int buf_size);
        return buf_size - 1;
    endfunction

endpackage

// File: rtl/mac_buf_ctrl_sva.sv
// Checker for the operand buffer: occupancy must match the pointer distance.
// Connects to the buffer's exported pointer/status ports only.
module mac_buf_ctrl_sva
    import mac_buf_ctrl_pkg::*;
#(
    parameter int BufferWidth = BUF_WIDTH_DEF,
    parameter int BufferSize  = BUF_SIZE_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic [BufferWidth-1:0] W_Addr,
    input logic [BufferWidth-1:0] R_Addr,
    input logic [BufferWidth:0]   Count,
    input logic                   Full
);

    function automatic int exp_count(input logic [BufferWidth-1:0] w,
                                     input logic [BufferWidth-1:0] r,
                                     input logic                   f);
        return ((int'(w) + BufferSize - int'(r)) % BufferSize) + (f ? BufferSize : 0);
    endfunction

    a_count_matches_ptrs: assert property (
        @(posedge clk) disable iff (!rst_n)
        int'(Count) == exp_count(W_Addr, R_Addr, Full)
    );

endmodule

// File: rtl/mac_wrap_ptr.sv
// Wrapping slot pointer for the MAC operand buffer.
// Wrap pulses combinationally in the cycle an increment happens at the last slot.
module mac_wrap_ptr
    import mac_buf_ctrl_pkg::*;
#(
    parameter int PtrWidth = BUF_WIDTH_DEF,
    parameter int PtrWrap  = ptr_wrap(BUF_SIZE_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Inc,
    output logic [PtrWidth-1:0] Ptr,
    output logic                Wrap
);

    localparam logic [PtrWidth-1:0] WRAP_VAL = PtrWidth'(PtrWrap);
    localparam logic [PtrWidth-1:0] PTR_ONE  = PtrWidth'(1);

    logic [PtrWidth-1:0] ptr_d;
    logic [PtrWidth-1:0] ptr_q;

    // Next pointer value and wrap pulse.
    always_comb begin
        ptr_d = ptr_q;
        Wrap  = 1'b0;
        if (Inc) begin
            if (ptr_q == WRAP_VAL) begin
                ptr_d = '0;
                Wrap  = 1'b1;
            end else begin
                ptr_d = ptr_q + PTR_ONE;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign Ptr = ptr_q;

endmodule

// File: rtl/mac_buf_ctrl.sv
// Circular operand buffer with valid/ready on both sides for the MAC input path.
// Full/empty come from pointer equality qualified by the lap bit Round.
module mac_buf_ctrl
    import mac_buf_ctrl_pkg::*;
#(
    parameter int BufferWidth = BUF_WIDTH_DEF,
    parameter int BufferSize  = BUF_SIZE_DEF,
    parameter int DataWidth   = DATA_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Wr_Valid,
    output logic                   Wr_Ready,
    input  logic [DataWidth-1:0]   Wr_Data,
    output logic                   Rd_Valid,
    input  logic                   Rd_Ready,
    output logic [DataWidth-1:0]   Rd_Data,
    output logic [BufferWidth-1:0] W_Addr,
    output logic [BufferWidth-1:0] R_Addr,
    output logic                   Round,
    output logic [BufferWidth:0]   Count,
    output logic                   Full,
    output logic                   Empty
);

    localparam logic [BufferWidth:0] CNT_ONE = (BufferWidth + 1)'(1);

    logic [DataWidth-1:0] mem_q [BufferSize];

    logic                 wr_fire_s;
    logic                 rd_fire_s;
    logic                 w_wrap_s;
    logic                 r_wrap_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 round_d;
    logic                 round_q;
    logic [BufferWidth:0] count_d;
    logic [BufferWidth:0] count_q;

    // Flags use only registered state, so no input reaches them combinationally.
    assign full_s    = (W_Addr == R_Addr) && round_q;
    assign empty_s   = (W_Addr == R_Addr) && !round_q;
    assign wr_fire_s = Wr_Valid && !full_s;
    assign rd_fire_s = Rd_Ready && !empty_s;

    mac_wrap_ptr #(
        .PtrWidth (BufferWidth),
        .PtrWrap  (ptr_wrap(BufferSize))
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .Inc   (wr_fire_s),
        .Ptr   (W_Addr),
        .Wrap  (w_wrap_s)
    );

    mac_wrap_ptr #(
        .PtrWidth (BufferWidth),
        .PtrWrap  (ptr_wrap(BufferSize))
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .Inc   (rd_fire_s),
        .Ptr   (R_Addr),
        .Wrap  (r_wrap_s)
    );

    // Lap bit and occupancy next-state; simultaneous wraps cancel.
    always_comb begin
        round_d = round_q ^ (w_wrap_s ^ r_wrap_s);
        count_d = count_q;
        case ({wr_fire_s, rd_fire_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Round and Count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q <= 1'b0;
            count_q <= '0;
        end else begin
            round_q <= round_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[W_Addr] <= Wr_Data;
        end
    end

    assign Rd_Data  = mem_q[R_Addr];
    assign Wr_Ready = !full_s;
    assign Rd_Valid = !empty_s;
    assign Full     = full_s;
    assign Empty    = empty_s;
    assign Round    = round_q;
    assign Count    = count_q;

endmodule
